// File: rtl/activation_unit.sv
// Multi-mode activation stage: snapshots a vector on start, transforms LANES elements per beat, commits all at once.
// Optional leaky-ReLU datapath is built only when ACTIVATION_LEAKY_EN is defined; otherwise mode 01 acts as ReLU.
module activation_unit #(
  parameter int FP_TOTAL_BITS = 16,
  parameter int FP_FRAC_BITS  = 8,
  parameter int NUM_CLASSES   = 4,
  parameter int LANES         = 1,
  parameter int LEAK_SHIFT    = 3,
  parameter int CLIP_INT      = 6
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic [1:0]                                   mode,
  input  logic [NUM_CLASSES-1:0][FP_TOTAL_BITS-1:0]    input_vector,
  output logic                                         busy,
  output logic                                         done,
  output logic [NUM_CLASSES-1:0][FP_TOTAL_BITS-1:0]    act_out
);

  localparam int W      = FP_TOTAL_BITS;
  localparam int N      = NUM_CLASSES / LANES;
  localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);

  localparam longint CEIL_RAW = longint'(CLIP_INT) << FP_FRAC_BITS;
  localparam longint MAX_POS  = (longint'(1) << (W - 1)) - 1;
  localparam logic signed [W-1:0] CLIP_CEIL = W'((CEIL_RAW > MAX_POS) ? MAX_POS : CEIL_RAW);

  if (NUM_CLASSES % LANES != 0) begin : g_bad_lanes
    $error("activation_unit: LANES must divide NUM_CLASSES");
  end
  if (LEAK_SHIFT < 1 || LEAK_SHIFT > W - 1) begin : g_bad_leak
    $error("activation_unit: LEAK_SHIFT out of range");
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                         r_state, w_state_next;
  logic                           w_accept, w_last;
  logic [BEAT_W-1:0]              r_beat;
  logic [1:0]                     r_mode;
  logic [NUM_CLASSES-1:0][W-1:0]  r_snap, r_shadow, r_act, w_shadow_next;
  logic                           r_done;

  function automatic logic [W-1:0] act_fn(input logic [W-1:0] x, input logic [1:0] m);
    logic sign;
    sign = x[W-1];
    case (m)
      2'b00:   return sign ? '0 : x;
`ifdef ACTIVATION_LEAKY_EN
      2'b01:   return sign ? W'($signed(x) >>> LEAK_SHIFT) : x;
`else
      2'b01:   return sign ? '0 : x;
`endif
      2'b10:   return sign ? '0 : (($signed(x) > CLIP_CEIL) ? CLIP_CEIL : x);
      default: return x;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_state_next = S_RUN;
        w_accept     = 1'b1;
      end
      S_RUN: if (r_beat == LAST_BEAT) begin
        w_state_next = S_IDLE;
        w_last       = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Current lane group overlaid on the shadow, so the final group reaches act_out on the commit edge.
  always_comb begin
    w_shadow_next = r_shadow;
    for (int l = 0; l < LANES; l++) begin
      w_shadow_next[int'(r_beat) * LANES + l] = act_fn(r_snap[int'(r_beat) * LANES + l], r_mode);
    end
  end

  // NOTE: the shadow and snapshot arrays are reset because an abort must leave no stale results behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat   <= '0;
      r_mode   <= 2'b00;
      r_snap   <= '0;
      r_shadow <= '0;
      r_act    <= '0;
      r_done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      r_done <= w_last;
      if (w_accept) begin
        r_snap <= input_vector;
        r_mode <= mode;
        r_beat <= '0;
      end
      if (r_state == S_RUN) begin
        r_shadow <= w_shadow_next;
        r_beat   <= r_beat + BEAT_W'(1);
        if (w_last) r_act <= w_shadow_next;
      end
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = r_done;
  assign act_out = r_act;

endmodule

// File: tb/tb_activation_unit.sv
// Self-checking bench for activation_unit: directed vectors, randomized vectors against an arithmetic model,
// reset abort and back-to-back throughput.
module tb_activation_unit;

  localparam int W      = 16;
  localparam int F      = 8;
  localparam int NC     = 4;
  localparam int LANES  = 1;
  localparam int LS     = 3;
  localparam int CLIP   = 6;
  localparam int N      = NC / LANES;

  typedef logic [NC-1:0][W-1:0] vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  vec_t       input_vector;
  logic       busy;
  logic       done;
  vec_t       act_out;

  int n_tests = 0;
  int n_fail  = 0;

  activation_unit #(
    .FP_TOTAL_BITS(W), .FP_FRAC_BITS(F), .NUM_CLASSES(NC),
    .LANES(LANES), .LEAK_SHIFT(LS), .CLIP_INT(CLIP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .input_vector(input_vector), .busy(busy), .done(done), .act_out(act_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the real-valued meaning of each element.
  function automatic logic [W-1:0] ref_elem(input logic [W-1:0] x, input logic [1:0] m);
    int v, r, ceil_v, div;
    v      = int'($signed(x));
    ceil_v = CLIP * (1 << F);
    if (ceil_v > (1 << (W - 1)) - 1) ceil_v = (1 << (W - 1)) - 1;
    div    = 1 << LS;
    case (m)
      2'd0: r = (v < 0) ? 0 : v;
`ifdef ACTIVATION_LEAKY_EN
      2'd1: r = (v < 0) ? -((-v + div - 1) / div) : v;
`else
      2'd1: r = (v < 0) ? 0 : v;
`endif
      2'd2: r = (v < 0) ? 0 : ((v > ceil_v) ? ceil_v : v);
      default: r = v;
    endcase
    return r[W-1:0];
  endfunction

  function automatic vec_t ref_vec(input vec_t v, input logic [1:0] m);
    vec_t r;
    for (int i = 0; i < NC; i++) r[i] = ref_elem(v[i], m);
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    for (int i = 0; i < NC; i++) begin
      case ($urandom_range(0, 5))
        0: r[i] = 16'h8000;
        1: r[i] = 16'h7FFF;
        2: r[i] = 16'h0600 + W'($urandom_range(0, 2)) - 16'h0001;
        3: r[i] = 16'hFFFF - W'($urandom_range(0, 8));
        default: r[i] = W'($urandom);
      endcase
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] a, b, c, d);
    vec_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  // Called 1ns after a rising edge with the DUT idle; returns likewise.
  task automatic run_vector(input string tag, input vec_t v, input logic [1:0] m,
                            input vec_t exp, input bit disturb);
    start = 1'b1; input_vector = v; mode = m;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < N; c++) begin
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_done_early"}, 64'(done), 64'd0);
      if (disturb) begin
        input_vector = rand_vec();
        mode         = 2'($urandom);
        start        = (c == 1);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    for (int i = 0; i < NC; i++) check($sformatf("%s_out[%0d]", tag, i), 64'(act_out[i]), 64'(exp[i]));
    @(posedge clk); #1;
    check({tag, "_done_single"}, 64'(done), 64'd0);
    check({tag, "_hold"}, 64'(act_out), 64'(exp));
  endtask

  initial begin
    vec_t v, e;
    int   done_at[$];
    bit   seen_done;

    reset = 1'b1; start = 1'b0; mode = 2'b00; input_vector = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_act", 64'(act_out), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors from the block's bring-up list.
    run_vector("relu", mk(16'h0180, 16'hFE00, 16'h0000, 16'h8000), 2'b00,
               mk(16'h0180, 16'h0000, 16'h0000, 16'h0000), 1'b0);
`ifdef ACTIVATION_LEAKY_EN
    e = mk(16'hFFC0, 16'hF000, 16'hFFFF, 16'h0100);
`else
    e = mk(16'h0000, 16'h0000, 16'h0000, 16'h0100);
`endif
    run_vector("leaky", mk(16'hFE00, 16'h8000, 16'hFFFF, 16'h0100), 2'b01, e, 1'b0);
    run_vector("clip", mk(16'h0700, 16'h0600, 16'h05FF, 16'hFF00), 2'b10,
               mk(16'h0600, 16'h0600, 16'h05FF, 16'h0000), 1'b0);
    v = mk(16'hFE00, 16'h1234, 16'h8000, 16'h7FFF);
    run_vector("ident", v, 2'b11, v, 1'b1);

    // Randomized vectors against the model, with inputs and start disturbed mid-run.
    for (int t = 0; t < 24; t++) begin
      logic [1:0] m;
      v = rand_vec();
      m = 2'($urandom);
      run_vector($sformatf("rnd%0d", t), v, m, ref_vec(v, m), bit'($urandom_range(0, 1)));
    end

    // Reset asserted mid-run (sampled at the beat-2 edge) aborts with no done.
    start = 1'b1; input_vector = mk(16'h0100, 16'h0200, 16'h0300, 16'h0400); mode = 2'b11;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_act", 64'(act_out), 64'd0);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < N + 2; c++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);

    // Simultaneous reset and start: start is dropped.
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check("rst_start_busy0", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("rst_start_busy1", 64'(busy), 64'd0);

    // Start held high: one done every N+1 cycles.
    v = rand_vec();
    start = 1'b1; input_vector = v; mode = 2'b10;
    @(posedge clk); #1;
    for (int c = 1; c <= 3 * (N + 1); c++) begin
      @(posedge clk); #1;
      if (done) done_at.push_back(c);
    end
    start = 1'b0;
    check("b2b_count", 64'(done_at.size()), 64'd3);
    for (int i = 0; i < done_at.size() && i < 3; i++)
      check($sformatf("b2b_at%0d", i), 64'(done_at[i]), 64'(N + i * (N + 1)));
    check("b2b_act", 64'(act_out), 64'(ref_vec(v, 2'b10)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/activation_unit.md
# activation_unit

Parametrised, multi-mode activation stage for the MLP datapath. It replaces the single-cycle ReLU between a layer's accumulator output and the next layer's input. A start pulse snapshots a vector of NUM_CLASSES signed fixed-point values and processes LANES elements per cycle using the selected activation. When the whole vector is finished, the block commits all results at once and pulses done.

## Interface
- FP_TOTAL_BITS, 16: element width, two's complement fixed point.
- FP_FRAC_BITS, 8: fractional bits (Q(FP_TOTAL_BITS-FP_FRAC_BITS).FP_FRAC_BITS).
- NUM_CLASSES, 4: elements per vector.
- LANES, 1: elements processed per cycle. Must divide NUM_CLASSES; elaboration error otherwise.
- LEAK_SHIFT, 3: leaky-ReLU negative slope, 2^-LEAK_SHIFT. Range 1..FP_TOTAL_BITS-1.
- CLIP_INT, 6: clipped-ReLU ceiling, integer part. Ceiling = CLIP_INT<<FP_FRAC_BITS, saturated to max positive if it does not fit.
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- mode  in  2  00 ReLU, 01 leaky ReLU, 10 clipped ReLU, 11 identity. Sampled with start.
- input_vector  in  NUM_CLASSES x FP_TOTAL_BITS signed  operand vector, sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when results are committed.
- act_out  out  NUM_CLASSES x FP_TOTAL_BITS signed  result vector. Holds until the next commit.

## Operation
- FSM states: IDLE, RUN.
- IDLE -> RUN on start:
  - input_vector and mode are captured into an internal snapshot.
  - Beat counter k is cleared to 0.
- RUN beat k (0..N-1, N=NUM_CLASSES/LANES):
  - Elements k*LANES .. k*LANES+LANES-1 of the snapshot are transformed.
  - Results are written to a shadow buffer.
  - k increments.
- RUN -> IDLE on beat N-1. On that same edge:
  - The shadow buffer (including the final lane group) is copied to act_out.
  - done <= 1.
- Element functions (x = snapshot element, sign = MSB):
  - ReLU: sign ? 0 : x.
  - Leaky: sign ? (x >>> LEAK_SHIFT) : x. Arithmetic shift, rounds toward minus infinity, so the result never overflows.
  - Clipped: sign ? 0 : min(x, ceiling).
  - Identity: x.
- Inputs change freely during RUN; only the snapshot is used.
- start while busy is ignored, not queued.
- reset wins over everything, including mid-RUN:
  - State goes to IDLE, k=0.
  - done=0, busy=0, act_out all zero, shadow buffer zeroed.
  - No done pulse is produced for the aborted vector.
- Simultaneous reset and start: reset wins and start is dropped.

## Timing
- Reset values: done=0, busy=0, act_out=all 0.
- start is sampled at edge E0. busy is high from after E0 through edge E0+N.
- Beats execute at edges E0+1 .. E0+N.
- act_out update and done=1 both become visible after edge E0+N.
- Latency is N cycles from the start-sampling edge to done.
  - LANES=NUM_CLASSES gives N=1, matching the legacy one-cycle ReLU latency.
- done is high for exactly one cycle. busy is already 0 in the done cycle.
- A start held high in the done cycle is accepted at the next edge. Back-to-back throughput is one vector per N+1 cycles.
- act_out never changes except at a commit edge or at reset.

## Configuration
- ACTIVATION_LEAKY_EN defined:
  - Leaky mode is implemented as above.
  - Each lane includes a barrel-free fixed shifter.
- ACTIVATION_LEAKY_EN undefined:
  - No leaky datapath is built.
  - mode 01 behaves exactly as mode 00 (ReLU).
  - All other modes and all timing are unchanged.

## Test plan
- ReLU, N=4 (LANES=1), input {0x0180, 0xFE00, 0x0000, 0x8000}:
  - After start: busy for 4 cycles.
  - done pulses at edge +4.
  - act_out = {0x0180, 0x0000, 0x0000, 0x0000}.
- Leaky (macro on, LEAK_SHIFT=3), input {0xFE00, 0x8000, 0xFFFF, 0x0100}:
  - act_out = {0xFFC0, 0xF000, 0xFFFF, 0x0100}.
- Leaky with macro off, same input:
  - act_out = {0x0000, 0x0000, 0x0000, 0x0100}.
- Clipped (CLIP_INT=6), input {0x0700, 0x0600, 0x05FF, 0xFF00}:
  - act_out = {0x0600, 0x0600, 0x05FF, 0x0000}.
- Identity, input {0xFE00, ...}:
  - act_out equals the snapshot.
  - input_vector changed during RUN does not affect the results.
  - start pulsed mid-RUN yields no extra done.
- Reset abort and back-to-back:
  - Reset asserted at beat 2: no done, act_out = 0.
  - After reset, start held high continuously gives a done every N+1 cycles.
